// File: rtl/msacc_pkg.sv
// msacc_pkg: shared definitions for the mean-square accumulator.
//   - FSM state encoding for mean_square_acc
//   - default sample width and window size
package msacc_pkg;

  localparam int BW_SAMPLE_DEF = 8;   // signed sample width
  localparam int LOG2_N_DEF    = 4;   // window = 2**LOG2_N_DEF samples

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    EMIT = 2'd3
  } state_e;

endpackage

// File: rtl/mean_square_acc_sq.sv
// sq_shift_add: sequential shift-add squarer, one partial product per cycle,
// LSB first.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : synchronous flush of all state (highest priority)
//   start_i       : load operand op_i, zero product and bit counter
//   step_i        : perform one shift-add iteration
//   op_i          : unsigned magnitude to square
//   prod_o        : running product (final after W steps)
//   last_o        : high while the W-th step is being taken
module sq_shift_add #(
  parameter int W = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clear_i,
  input  logic           start_i,
  input  logic           step_i,
  input  logic [W-1:0]   op_i,
  output logic [2*W-1:0] prod_o,
  output logic           last_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [2*W-1:0] prod_q;
  logic [CW-1:0]  cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      mcand_q  <= {{W{1'b0}}, op_i};
      mplier_q <= op_i;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      if (mplier_q[0]) prod_q <= prod_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

  assign prod_o = prod_q;
  assign last_o = step_i && (cnt_q == CW'(W - 1));

endmodule

// File: rtl/mean_square_acc.sv
// mean_square_acc: accumulates squares of 2**log2_n signed samples and emits
// their mean square to a downstream square-root stage.
//   Clock, Reset_n : clock, async active-low reset
//   Clear          : synchronous window restart (drops any in-flight sample)
//   InValid/InData : sample handshake input, InReady = block idle
//   SqrtBusy       : downstream busy, holds the result in EMIT
//   MsOut          : mean square of the last complete window
//   Start          : one-cycle pulse when MsOut is freshly loaded
// Build option: define MSACC_ROUND_EN for round-half-up with saturation;
// otherwise the mean is truncated. Timing is identical either way.
module mean_square_acc
  import msacc_pkg::*;
#(
  parameter int bw_sample = BW_SAMPLE_DEF,
  parameter int log2_n    = LOG2_N_DEF
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Clear,
  input  logic                   InValid,
  input  logic [bw_sample-1:0]   InData,
  output logic                   InReady,
  input  logic                   SqrtBusy,
  output logic [2*bw_sample-1:0] MsOut,
  output logic                   Start
);

  localparam int PW   = 2 * bw_sample;      // square width
  localparam int AW   = PW + log2_n;        // accumulator width
  localparam int CNTW = log2_n + 1;         // must hold 2**log2_n itself

  state_e          state_q;
  logic [AW-1:0]   acc_q;
  logic [CNTW-1:0] cnt_q;
  logic [PW-1:0]   ms_q;
  logic            start_q;

  logic [bw_sample-1:0] mag;
  logic [PW-1:0]        prod;
  logic                 sq_last;
  logic                 xfer;
  logic [CNTW-1:0]      cnt_inc;
  logic [PW-1:0]        ms_d;

  // Two's-complement magnitude; the most negative value wraps to
  // 2**(bw_sample-1), which still fits as unsigned.
  assign mag     = InData[bw_sample-1] ? (~InData + bw_sample'(1)) : InData;
  assign xfer    = InValid && (state_q == IDLE) && !Clear;
  assign cnt_inc = cnt_q + CNTW'(1);

`ifdef MSACC_ROUND_EN
  localparam logic [AW:0] HALF = {{AW{1'b0}}, 1'b1} << (log2_n - 1);
  logic [AW:0] rnd;
  assign rnd  = {1'b0, acc_q} + HALF;
  assign ms_d = (|(rnd >> (PW + log2_n))) ? {PW{1'b1}} : PW'(rnd >> log2_n);
`else
  assign ms_d = PW'(acc_q >> log2_n);
`endif

  sq_shift_add #(.W(bw_sample)) u_sq (
    .clk_i   (Clock),
    .rst_ni  (Reset_n),
    .clear_i (Clear),
    .start_i (xfer),
    .step_i  (state_q == MUL),
    .op_i    (mag),
    .prod_o  (prod),
    .last_o  (sq_last)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ms_q    <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (Clear) begin
        state_q <= IDLE;
        acc_q   <= '0;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: if (InValid) state_q <= MUL;
          MUL:  if (sq_last) state_q <= ACC;
          ACC: begin
            acc_q   <= acc_q + AW'(prod);
            cnt_q   <= cnt_inc;
            state_q <= (cnt_inc == CNTW'(1 << log2_n)) ? EMIT : IDLE;
          end
          EMIT: if (!SqrtBusy) begin
            ms_q    <= ms_d;
            start_q <= 1'b1;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign InReady = (state_q == IDLE);
  assign MsOut   = ms_q;
  assign Start   = start_q;

endmodule
